// File: rtl/rom_uart_loader.sv
// Boot loader: receives a framed program image over 8N1 UART and writes it into the
// instruction ROM word by word, holding the core in reset until the image is complete.
module rom_uart_loader #(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD           = 115200,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_waddr,
    output logic [31:0]           rom_wdata,
    output logic                  core_rst_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int CPB_RAW      = CLK_FREQ / BAUD;
    localparam int CLKS_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      CAPACITY  = 17'(1) << ADDR_WIDTH;
    localparam logic [7:0]       SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;

    // RX front end
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    // Frame loader
    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           idx_q, idx_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           asm_q, asm_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  rom_we_q, rom_we_d;
    logic [ADDR_WIDTH-1:0] rom_waddr_q, rom_waddr_d;
    logic [31:0]           rom_wdata_q, rom_wdata_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  load_busy_q, load_busy_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  in_frame;
    logic                  sync_seen;
    logic [15:0]           word_len;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + CNT_W'(1);
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Mid-bit re-check filters short glitches on the line
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                    rx_state_d   = RX_IDLE;
                end
            end
        endcase
    end

    assign in_frame  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
    assign sync_seen = byte_valid_q && (rx_shift_q == SYNC_BYTE);

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        count_d     = count_q;
        idx_d       = idx_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        tmo_d       = '0;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
        word_len    = {rx_shift_q, len_lo_q};
        case (state_q)
            IDLE, DONE, ERR: begin
                if (sync_seen) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (byte_valid_q) begin
                    len_lo_d = rx_shift_q;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (byte_valid_q) begin
                    if (word_len == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, word_len} > CAPACITY) begin
                        state_d = ERR;
                    end else begin
                        count_d    = word_len;
                        idx_d      = '0;
                        byte_cnt_d = '0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_valid_q) begin
                    asm_d      = {rx_shift_q, asm_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        rom_we_d    = 1'b1;
                        rom_wdata_d = {rx_shift_q, asm_q[31:8]};
                        rom_waddr_d = idx_q[ADDR_WIDTH-1:0];
                        idx_d       = idx_q + 16'd1;
                        if (idx_q == count_q - 16'd1) state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Framing errors and inter-byte silence abort only an in-progress frame
        if (in_frame) begin
            if (frame_err_q) begin
                state_d = ERR;
            end else if (!byte_valid_q) begin
                if (tmo_q == TMO_LAST) state_d = ERR;
                else tmo_d = tmo_q + TMO_W'(1);
            end
        end
        load_busy_d  = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
        load_done_d  = (state_q == DONE) && (state_d == DONE);
        core_rst_n_d = (state_q == DONE) && (state_d == DONE);
        load_err_d   = (state_q == ERR) && (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= IDLE;
            len_lo_q     <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            tmo_q        <= '0;
            rom_we_q     <= 1'b0;
            rom_waddr_q  <= '0;
            rom_wdata_q  <= '0;
            core_rst_n_q <= 1'b0;
            load_busy_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            tmo_q        <= tmo_d;
            rom_we_q     <= rom_we_d;
            rom_waddr_q  <= rom_waddr_d;
            rom_wdata_q  <= rom_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            load_busy_q  <= load_busy_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_waddr  = rom_waddr_q;
    assign rom_wdata  = rom_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign load_busy  = load_busy_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed bench for rom_uart_loader: streams framed images over a 10-clk/bit UART line
// and checks ROM writes, core reset release, error handling and reload.
module tb_rom_uart_loader;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uart_rx = 1'b1;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          core_rst_n, load_busy, load_done, load_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fall_cyc = -1;
    logic core_prev = 1'b0;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [7:0]    tx_q[$];

    rom_uart_loader #(
        .CLK_FREQ(50000000), .BAUD(5000000), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(500)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .core_rst_n(core_rst_n), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log and core_rst_n falling-edge timestamp, sampled mid-cycle
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            wr_addr.push_back(rom_waddr);
            wr_data.push_back(rom_wdata);
        end
        if (core_prev === 1'b1 && core_rst_n === 1'b0) fall_cyc = cyc;
        core_prev = core_rst_n;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        start_cyc = cyc;
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = stop;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_queue();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (load_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({rom_we, rom_waddr, rom_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_rom: we/addr/data=%b/%h/%h want 0/0/0", rom_we, rom_waddr, rom_wdata);
        end
        checks++;
        if ({core_rst_n, load_busy, load_done, load_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b want 0000", {core_rst_n, load_busy, load_done, load_err});
        end
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if ({core_rst_n, load_busy, load_done, load_err} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_status: got %b want 0000", {core_rst_n, load_busy, load_done, load_err});
        end
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL idle_writes: got %0d want 0", wr_addr.size());
        end
    endtask

    task automatic test_two_words();
        int base;
        bit ok;
        base = wr_addr.size();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_queue();
        wait_done(50, ok);
        settle();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL two_done_wait: load_done=%b want 1", load_done);
        end
        checks++;
        if (wr_addr.size() - base != 2) begin
            errors++;
            $display("FAIL two_count: got %0d writes want 2", wr_addr.size() - base);
        end else begin
            checks++;
            if (wr_addr[base] !== 12'd0 || wr_data[base] !== 32'h00100513) begin
                errors++;
                $display("FAIL two_w0: got %h/%h want 000/00100513", wr_addr[base], wr_data[base]);
            end
            checks++;
            if (wr_addr[base+1] !== 12'd1 || wr_data[base+1] !== 32'h00200593) begin
                errors++;
                $display("FAIL two_w1: got %h/%h want 001/00200593", wr_addr[base+1], wr_data[base+1]);
            end
        end
        checks++;
        if ({core_rst_n, load_busy, load_done, load_err} !== 4'b1010) begin
            errors++;
            $display("FAIL two_status: got %b want 1010", {core_rst_n, load_busy, load_done, load_err});
        end
    endtask

    task automatic test_noise_empty();
        int base;
        bit ok;
        base = wr_addr.size();
        tx_q = '{8'h00, 8'hFF};
        send_queue();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        tx_q = '{8'hA5, 8'h00, 8'h00};
        send_queue();
        wait_done(50, ok);
        settle();
        checks++;
        if (!ok || core_rst_n !== 1'b1 || load_err !== 1'b0 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_status: got %b want 1010", {core_rst_n, load_busy, load_done, load_err});
        end
        checks++;
        if (wr_addr.size() != base) begin
            errors++;
            $display("FAIL empty_writes: got %0d want 0", wr_addr.size() - base);
        end
    endtask

    task automatic test_timeout();
        int base;
        bit ok;
        base = wr_addr.size();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05};
        send_queue();
        repeat (600) @(negedge clk);
        #1;
        checks++;
        if ({core_rst_n, load_busy, load_done, load_err} !== 4'b0001) begin
            errors++;
            $display("FAIL tmo_status: got %b want 0001", {core_rst_n, load_busy, load_done, load_err});
        end
        checks++;
        if (wr_addr.size() != base) begin
            errors++;
            $display("FAIL tmo_writes: got %0d want 0", wr_addr.size() - base);
        end
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
        send_queue();
        wait_done(50, ok);
        settle();
        checks++;
        if (!ok || load_err !== 1'b0 || core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL tmo_recover: got %b want 1010", {core_rst_n, load_busy, load_done, load_err});
        end
        checks++;
        if (wr_addr.size() - base != 1 || wr_addr[$] !== 12'd0 || wr_data[$] !== 32'h00100513) begin
            errors++;
            $display("FAIL tmo_rewrite: got %0d writes last %h/%h want 1 000/00100513",
                     wr_addr.size() - base, wr_addr[$], wr_data[$]);
        end
    endtask

    task automatic test_bad_stop_oversize();
        int base;
        base = wr_addr.size();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h13};
        send_queue();
        send_byte(8'h05, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if ({load_busy, load_err, core_rst_n} !== 3'b010) begin
            errors++;
            $display("FAIL badstop_err: busy/err/core=%b want 010", {load_busy, load_err, core_rst_n});
        end
        // Exactly capacity (4096) is accepted and enters DATA
        tx_q = '{8'hA5, 8'h00, 8'h10};
        send_queue();
        settle();
        checks++;
        if ({load_busy, load_err} !== 2'b10) begin
            errors++;
            $display("FAIL cap_accept: busy/err=%b want 10", {load_busy, load_err});
        end
        repeat (600) @(negedge clk);
        tx_q = '{8'hA5, 8'h01};
        send_queue();
        settle();
        checks++;
        if ({load_busy, load_err} !== 2'b10) begin
            errors++;
            $display("FAIL over_len_lo: busy/err=%b want 10", {load_busy, load_err});
        end
        send_byte(8'h10, 1'b1);
        settle();
        checks++;
        if ({load_busy, load_err, core_rst_n} !== 3'b010) begin
            errors++;
            $display("FAIL over_err: busy/err/core=%b want 010", {load_busy, load_err, core_rst_n});
        end
        checks++;
        if (wr_addr.size() != base) begin
            errors++;
            $display("FAIL over_writes: got %0d want 0", wr_addr.size() - base);
        end
    endtask

    task automatic test_reload();
        int base;
        int sync_start;
        bit ok;
        tx_q = '{8'hA5, 8'h00, 8'h00};
        send_queue();
        wait_done(50, ok);
        settle();
        checks++;
        if (!ok || core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reload_pre: done/core=%b%b want 11", load_done, core_rst_n);
        end
        base = wr_addr.size();
        fall_cyc = -1;
        send_byte(8'hA5, 1'b1);
        sync_start = start_cyc;
        // Start edge + 2-flop sync + half bit + 9 bit periods puts byte_valid at
        // cycle 98 of the byte, so core_rst_n is low from cycle 99.
        checks++;
        if (fall_cyc - sync_start != 99 || core_rst_n !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL reload_drop: fall at +%0d core=%b done=%b want +99 0 0",
                     fall_cyc - sync_start, core_rst_n, load_done);
        end
        tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_queue();
        wait_done(50, ok);
        settle();
        checks++;
        if (wr_addr.size() - base != 1 || wr_addr[$] !== 12'd0 || wr_data[$] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reload_write: got %0d writes last %h/%h want 1 000/deadbeef",
                     wr_addr.size() - base, wr_addr[$], wr_data[$]);
        end
        checks++;
        if (!ok || core_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reload_release: done/core=%b%b want 11", load_done, core_rst_n);
        end
    endtask

    task automatic test_reset_mid_data();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_queue();
        settle();
        checks++;
        if (load_busy !== 1'b1 || rom_wdata !== 32'h44332211) begin
            errors++;
            $display("FAIL mid_pre: busy=%b data=%h want 1 44332211", load_busy, rom_wdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rom_we, rom_waddr, rom_wdata, core_rst_n, load_busy, load_done, load_err} !== '0) begin
            errors++;
            $display("FAIL mid_async_clear: data=%h status=%b want 0", rom_wdata,
                     {core_rst_n, load_busy, load_done, load_err});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        checks++;
        if ({core_rst_n, load_busy, load_done, load_err} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_after: got %b want 0000", {core_rst_n, load_busy, load_done, load_err});
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_noise_empty();
        test_timeout();
        test_bad_stop_oversize();
        test_reload();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
